// File: rtl/obi_interconnect_master_arb.sv
// obi_interconnect_master_arb: per-slave OBI arbiter.
//
// Shares one OBI slave port between MASTERS requesters. One requesting master
// is selected per cycle, its address-phase signals are muxed onto the slave
// port, and the selection is held until the slave grants. Each granted master
// index is pushed into an in-order ID FIFO so that every slave response is
// routed back to the master that issued the request.
//
// Configuration macro:
//   OBI_ARB_ROUND_ROBIN_EN  defined   -> round-robin arbitration (rr_ptr kept)
//                           undefined -> fixed priority, lowest index wins
//
// Ports:
//   clk_i            clock
//   rst_ni           synchronous active-low reset
//   master_req_i     per-master request (already slave-select qualified)
//   master_addr_i    per-master address
//   master_we_i      per-master write enable
//   master_be_i      per-master byte enables
//   master_wdata_i   per-master write data
//   master_gnt_o     per-master grant (one-hot or zero)
//   master_rvalid_o  per-master response valid (one-hot or zero)
//   master_rdata_o   slave read data broadcast to all masters
//   slave_req_o      request to slave
//   slave_addr_o     muxed address
//   slave_we_o       muxed write enable
//   slave_be_o       muxed byte enables
//   slave_wdata_o    muxed write data
//   slave_gnt_i      slave grant
//   slave_rvalid_i   slave response valid
//   slave_rdata_i    slave read data
//   err_o            sticky: response received with no outstanding ID
module obi_interconnect_master_arb #(
    parameter int unsigned MASTERS     = 2,
    parameter int unsigned OUTSTANDING = 2,
    parameter int unsigned MASTER_BITS = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [MASTERS-1:0]        master_req_i,
    input  logic [MASTERS-1:0][31:0]  master_addr_i,
    input  logic [MASTERS-1:0]        master_we_i,
    input  logic [MASTERS-1:0][3:0]   master_be_i,
    input  logic [MASTERS-1:0][31:0]  master_wdata_i,
    output logic [MASTERS-1:0]        master_gnt_o,
    output logic [MASTERS-1:0]        master_rvalid_o,
    output logic [31:0]               master_rdata_o,
    output logic                      slave_req_o,
    output logic [31:0]               slave_addr_o,
    output logic                      slave_we_o,
    output logic [3:0]                slave_be_o,
    output logic [31:0]               slave_wdata_o,
    input  logic                      slave_gnt_i,
    input  logic                      slave_rvalid_i,
    input  logic [31:0]               slave_rdata_i,
    output logic                      err_o
);

    localparam int unsigned PtrBits = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int unsigned CntBits = $clog2(OUTSTANDING + 1);

    typedef enum logic {
        StIdle,
        StWait
    } state_e;

    state_e                 state_q, state_d;
    logic [MASTER_BITS-1:0] lock_id_q, lock_id_d;
    logic [MASTER_BITS-1:0] winner;
    logic [MASTER_BITS-1:0] sel;
    logic                   found;
    int unsigned            idx;

    logic [MASTER_BITS-1:0] fifo_q [OUTSTANDING];
    logic [PtrBits-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CntBits-1:0]     count_q;
    logic [CntBits:0]       occupancy;
    logic                   fifo_full, fifo_empty;
    logic                   handshake, pop;
    logic [MASTER_BITS-1:0] head;
    logic                   err_q;

`ifdef OBI_ARB_ROUND_ROBIN_EN
    logic [MASTER_BITS-1:0] rr_ptr_q;
`endif

    // Winner search: first requester starting at rr_ptr (round-robin) or at
    // index 0 (fixed priority).
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < MASTERS; i++) begin
`ifdef OBI_ARB_ROUND_ROBIN_EN
            idx = 32'(rr_ptr_q) + i;
            if (idx >= MASTERS) begin
                idx = idx - MASTERS;
            end
`else
            idx = i;
`endif
            if (!found && master_req_i[MASTER_BITS'(idx)]) begin
                found  = 1'b1;
                winner = MASTER_BITS'(idx);
            end
        end
    end

    // A WAIT reservation counts as an occupied FIFO slot, so the push on the
    // eventual grant always has room.
    assign occupancy  = {1'b0, count_q} + {{CntBits{1'b0}}, (state_q == StWait)};
    assign fifo_full  = occupancy >= (CntBits + 1)'(OUTSTANDING);
    assign fifo_empty = (count_q == '0);

    // Address-phase FSM: next state and slave request.
    always_comb begin
        state_d     = state_q;
        lock_id_d   = lock_id_q;
        sel         = winner;
        slave_req_o = 1'b0;
        case (state_q)
            StIdle: begin
                sel         = winner;
                slave_req_o = rst_ni & (|master_req_i) & ~fifo_full;
                if (slave_req_o && !slave_gnt_i) begin
                    state_d   = StWait;
                    lock_id_d = winner;
                end
            end
            StWait: begin
                // Selection frozen; request held even if the master drops it.
                sel         = lock_id_q;
                slave_req_o = rst_ni;
                if (slave_gnt_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign handshake = slave_req_o & slave_gnt_i;
    assign pop       = rst_ni & slave_rvalid_i & ~fifo_empty;
    assign head      = fifo_q[rd_ptr_q];

    assign slave_addr_o   = master_addr_i[sel];
    assign slave_we_o     = master_we_i[sel];
    assign slave_be_o     = master_be_i[sel];
    assign slave_wdata_o  = master_wdata_i[sel];
    assign master_rdata_o = slave_rdata_i;
    assign err_o          = err_q;

    always_comb begin
        master_gnt_o    = '0;
        master_rvalid_o = '0;
        master_gnt_o[sel] = handshake;
        if (pop) begin
            master_rvalid_o[head] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            lock_id_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
        end
    end

`ifdef OBI_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else if (handshake) begin
            rr_ptr_q <= (sel == MASTER_BITS'(MASTERS - 1)) ? '0 : sel + MASTER_BITS'(1);
        end
    end
`endif

    // ID storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk_i) begin
        if (handshake) begin
            fifo_q[wr_ptr_q] <= sel;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (handshake) begin
                wr_ptr_q <= (wr_ptr_q == PtrBits'(OUTSTANDING - 1)) ? '0
                                                                     : wr_ptr_q + PtrBits'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrBits'(OUTSTANDING - 1)) ? '0
                                                                     : rd_ptr_q + PtrBits'(1);
            end
            case ({handshake, pop})
                2'b10:   count_q <= count_q + CntBits'(1);
                2'b01:   count_q <= count_q - CntBits'(1);
                default: count_q <= count_q;
            endcase
            if (slave_rvalid_i && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_obi_interconnect_master_arb.sv
// Self-checking bench for obi_interconnect_master_arb (MASTERS=2, OUTSTANDING=2).
// A queue-based reference model predicts grants, responses and the error flag.
module tb_obi_interconnect_master_arb;

    localparam int M = 2;
    localparam int O = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [M-1:0]      req;
    logic [M-1:0][31:0] addr;
    logic [M-1:0]      we;
    logic [M-1:0][3:0] be;
    logic [M-1:0][31:0] wdata;
    logic [M-1:0]      gnt_o;
    logic [M-1:0]      rvalid_o;
    logic [31:0]       rdata_o;
    logic              sreq;
    logic [31:0]       saddr;
    logic              swe;
    logic [3:0]        sbe;
    logic [31:0]       swdata;
    logic              sgnt;
    logic              srvalid;
    logic [31:0]       srdata;
    logic              err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int   q[$];
    bit   m_lock;
    int   m_lock_id;
    int   m_rr;
    logic m_err;
    // Model predictions for the current cycle
    int           e_sel;
    logic         e_sreq;
    logic [M-1:0] e_gnt;
    logic [M-1:0] e_rvalid;

    always #5 clk = ~clk;

    obi_interconnect_master_arb #(
        .MASTERS     (M),
        .OUTSTANDING (O)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .master_req_i    (req),
        .master_addr_i   (addr),
        .master_we_i     (we),
        .master_be_i     (be),
        .master_wdata_i  (wdata),
        .master_gnt_o    (gnt_o),
        .master_rvalid_o (rvalid_o),
        .master_rdata_o  (rdata_o),
        .slave_req_o     (sreq),
        .slave_addr_o    (saddr),
        .slave_we_o      (swe),
        .slave_be_o      (sbe),
        .slave_wdata_o   (swdata),
        .slave_gnt_i     (sgnt),
        .slave_rvalid_i  (srvalid),
        .slave_rdata_i   (srdata),
        .err_o           (err)
    );

    function automatic int winner(input logic [M-1:0] r);
        for (int i = 0; i < M; i++) begin
            int k;
`ifdef OBI_ARB_ROUND_ROBIN_EN
            k = (m_rr + i) % M;
`else
            k = i;
`endif
            if (r[k]) return k;
        end
        return 0;
    endfunction

    task automatic model_eval();
        if (!rst_n) begin
            e_sel = 0; e_sreq = 1'b0; e_gnt = '0; e_rvalid = '0;
        end else begin
            if (m_lock) begin
                e_sel  = m_lock_id;
                e_sreq = 1'b1;
            end else begin
                e_sel  = winner(req);
                e_sreq = (req != '0) && (q.size() < O);
            end
            e_gnt    = (e_sreq && sgnt) ? (M'(1) << e_sel) : '0;
            e_rvalid = (srvalid && q.size() > 0) ? (M'(1) << q[0]) : '0;
        end
    endtask

    task automatic model_tick();
        if (!rst_n) begin
            q.delete(); m_lock = 0; m_rr = 0; m_err = 1'b0;
        end else begin
            if (srvalid) begin
                if (q.size() > 0) void'(q.pop_front());
                else m_err = 1'b1;
            end
            if (e_sreq && sgnt) begin
                q.push_back(e_sel);
                m_rr   = (e_sel + 1) % M;
                m_lock = 0;
            end else if (e_sreq) begin
                m_lock    = 1;
                m_lock_id = e_sel;
            end
        end
    endtask

    // Apply one cycle of stimulus at the falling edge, then predict outputs.
    task automatic drive(input logic r_n, input logic [M-1:0] r, input logic g,
                         input logic v, input bit np);
        @(negedge clk);
        rst_n = r_n; req = r; sgnt = g; srvalid = v; srdata = $urandom;
        if (np) begin
            for (int i = 0; i < M; i++) begin
                addr[i] = $urandom; wdata[i] = $urandom;
                we[i] = 1'($urandom_range(0, 1)); be[i] = 4'($urandom_range(0, 15));
            end
        end
        #1;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_tick();
    endtask

    task automatic test_reset();
        drive(1'b0, 2'b11, 1'b1, 1'b1, 1'b1);
        n_checks++; if (sreq !== 1'b0) begin n_errors++; $display("FAIL reset_req: got %b expected 0", sreq); end
        n_checks++; if (gnt_o !== 2'b00) begin n_errors++; $display("FAIL reset_gnt: got %b expected 00", gnt_o); end
        n_checks++; if (rvalid_o !== 2'b00) begin n_errors++; $display("FAIL reset_rvalid: got %b expected 00", rvalid_o); end
        tick();
        drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b expected 0", err); end
        n_checks++; if (sreq !== 1'b0) begin n_errors++; $display("FAIL idle_req: got %b expected 0", sreq); end
        tick();
    endtask

    task automatic test_arbitration();
        logic [M-1:0] exp_g, prev_g;
        prev_g = '0;
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 2'b11, 1'b1, k > 0, 1'b0);
`ifdef OBI_ARB_ROUND_ROBIN_EN
            exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
`else
            exp_g = 2'b01;
`endif
            n_checks++; if (gnt_o !== exp_g) begin n_errors++; $display("FAIL arb_gnt[%0d]: got %b expected %b", k, gnt_o, exp_g); end
            if (k > 0) begin
                n_checks++; if (rvalid_o !== prev_g) begin n_errors++; $display("FAIL arb_rvalid[%0d]: got %b expected %b", k, rvalid_o, prev_g); end
                n_checks++; if (rdata_o !== srdata) begin n_errors++; $display("FAIL arb_rdata[%0d]: got %h expected %h", k, rdata_o, srdata); end
            end
            prev_g = exp_g;
            tick();
        end
        drive(1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        n_checks++; if (rvalid_o !== prev_g) begin n_errors++; $display("FAIL arb_drain: got %b expected %b", rvalid_o, prev_g); end
        tick();
    endtask

    task automatic test_wait_lock();
        drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
        n_checks++; if (sreq !== 1'b1) begin n_errors++; $display("FAIL lock_req0: got %b expected 1", sreq); end
        n_checks++; if (gnt_o !== 2'b00) begin n_errors++; $display("FAIL lock_gnt0: got %b expected 00", gnt_o); end
        n_checks++; if (saddr !== addr[1]) begin n_errors++; $display("FAIL lock_addr0: got %h expected %h", saddr, addr[1]); end
        tick();
        for (int k = 1; k < 3; k++) begin
            drive(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
            n_checks++; if (sreq !== 1'b1) begin n_errors++; $display("FAIL lock_req%0d: got %b expected 1", k, sreq); end
            n_checks++; if ({saddr, swe, sbe, swdata} !== {addr[1], we[1], be[1], wdata[1]})
                begin n_errors++; $display("FAIL lock_payload%0d: got %h expected %h", k, saddr, addr[1]); end
            tick();
        end
        drive(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
        n_checks++; if (gnt_o !== 2'b10) begin n_errors++; $display("FAIL lock_gnt3: got %b expected 10", gnt_o); end
        n_checks++; if (saddr !== addr[1]) begin n_errors++; $display("FAIL lock_addr3: got %h expected %h", saddr, addr[1]); end
        tick();
        drive(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
        n_checks++; if (gnt_o !== 2'b01) begin n_errors++; $display("FAIL lock_next_gnt: got %b expected 01", gnt_o); end
        n_checks++; if (saddr !== addr[0]) begin n_errors++; $display("FAIL lock_next_addr: got %h expected %h", saddr, addr[0]); end
        tick();
        drive(1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        n_checks++; if (rvalid_o !== 2'b10) begin n_errors++; $display("FAIL lock_rsp0: got %b expected 10", rvalid_o); end
        tick();
        drive(1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        n_checks++; if (rvalid_o !== 2'b01) begin n_errors++; $display("FAIL lock_rsp1: got %b expected 01", rvalid_o); end
        tick();
    endtask

    task automatic test_fifo_full();
        int g[3];
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
            n_checks++; if (gnt_o !== e_gnt || sreq !== 1'b1) begin n_errors++; $display("FAIL full_gnt%0d: got %b expected %b", k, gnt_o, e_gnt); end
            g[k] = e_sel;
            tick();
        end
        drive(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
        n_checks++; if (sreq !== 1'b0 || gnt_o !== 2'b00) begin n_errors++; $display("FAIL full_block: got req=%b gnt=%b expected req=0 gnt=00", sreq, gnt_o); end
        tick();
        drive(1'b1, 2'b11, 1'b1, 1'b1, 1'b0);
        n_checks++; if (sreq !== 1'b0) begin n_errors++; $display("FAIL full_no_bypass: got %b expected 0", sreq); end
        n_checks++; if (rvalid_o !== (M'(1) << g[0])) begin n_errors++; $display("FAIL full_rsp0: got %b expected %b", rvalid_o, M'(1) << g[0]); end
        tick();
        drive(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
        n_checks++; if (sreq !== 1'b1 || gnt_o !== e_gnt) begin n_errors++; $display("FAIL full_third: got req=%b gnt=%b expected req=1 gnt=%b", sreq, gnt_o, e_gnt); end
        g[2] = e_sel;
        tick();
        for (int k = 1; k < 3; k++) begin
            drive(1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
            n_checks++; if (rvalid_o !== (M'(1) << g[k])) begin n_errors++; $display("FAIL full_rsp%0d: got %b expected %b", k, rvalid_o, M'(1) << g[k]); end
            tick();
        end
    endtask

    task automatic test_push_pop();
        drive(1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
        n_checks++; if (gnt_o !== 2'b01) begin n_errors++; $display("FAIL pp_setup: got %b expected 01", gnt_o); end
        tick();
        drive(1'b1, 2'b10, 1'b1, 1'b1, 1'b0);
        n_checks++; if (gnt_o !== 2'b10) begin n_errors++; $display("FAIL pp_gnt: got %b expected 10", gnt_o); end
        n_checks++; if (rvalid_o !== 2'b01) begin n_errors++; $display("FAIL pp_rvalid: got %b expected 01", rvalid_o); end
        tick();
        drive(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
        n_checks++; if (sreq !== 1'b1) begin n_errors++; $display("FAIL pp_count1: got %b expected 1", sreq); end
        tick();
        drive(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
        n_checks++; if (sreq !== 1'b0) begin n_errors++; $display("FAIL pp_count2: got %b expected 0", sreq); end
        tick();
        drive(1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        n_checks++; if (rvalid_o !== 2'b10) begin n_errors++; $display("FAIL pp_rsp1: got %b expected 10", rvalid_o); end
        tick();
        drive(1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        n_checks++; if (rvalid_o !== e_rvalid) begin n_errors++; $display("FAIL pp_rsp2: got %b expected %b", rvalid_o, e_rvalid); end
        tick();
    endtask

    task automatic test_random();
        logic v;
        for (int k = 0; k < 400; k++) begin
            v = (q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            drive(1'b1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), v, 1'b1);
            n_checks++; if (sreq !== e_sreq) begin n_errors++; $display("FAIL rnd_req[%0d]: got %b expected %b", k, sreq, e_sreq); end
            n_checks++; if (gnt_o !== e_gnt) begin n_errors++; $display("FAIL rnd_gnt[%0d]: got %b expected %b", k, gnt_o, e_gnt); end
            n_checks++; if (rvalid_o !== e_rvalid) begin n_errors++; $display("FAIL rnd_rvalid[%0d]: got %b expected %b", k, rvalid_o, e_rvalid); end
            n_checks++; if (err !== m_err) begin n_errors++; $display("FAIL rnd_err[%0d]: got %b expected %b", k, err, m_err); end
            if (e_sreq) begin
                n_checks++;
                if ({saddr, swe, sbe, swdata} !== {addr[e_sel], we[e_sel], be[e_sel], wdata[e_sel]}) begin
                    n_errors++; $display("FAIL rnd_mux[%0d]: got %h expected %h", k, saddr, addr[e_sel]);
                end
            end
            if (e_rvalid != '0) begin
                n_checks++; if (rdata_o !== srdata) begin n_errors++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", k, rdata_o, srdata); end
            end
            tick();
        end
        // Close any held request, then drain responses.
        drive(1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < O + 1 && q.size() > 0; k++) begin
            drive(1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
            n_checks++; if (rvalid_o !== e_rvalid) begin n_errors++; $display("FAIL rnd_drain[%0d]: got %b expected %b", k, rvalid_o, e_rvalid); end
            tick();
        end
    endtask

    task automatic test_err();
        drive(1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL err_pre: got %b expected 0", err); end
        n_checks++; if (rvalid_o !== 2'b00) begin n_errors++; $display("FAIL err_rvalid: got %b expected 00", rvalid_o); end
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
            n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL err_sticky[%0d]: got %b expected 1", k, err); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
        n_checks++; if (gnt_o !== 2'b01) begin n_errors++; $display("FAIL mid_setup: got %b expected 01", gnt_o); end
        tick();
        drive(1'b0, 2'b11, 1'b1, 1'b1, 1'b0);
        n_checks++; if (sreq !== 1'b0 || gnt_o !== 2'b00 || rvalid_o !== 2'b00)
            begin n_errors++; $display("FAIL mid_reset_outs: got req=%b gnt=%b rvalid=%b expected 0/00/00", sreq, gnt_o, rvalid_o); end
        tick();
        drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL mid_err_clear: got %b expected 0", err); end
        tick();
        drive(1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        n_checks++; if (rvalid_o !== 2'b00) begin n_errors++; $display("FAIL mid_stray: got %b expected 00", rvalid_o); end
        tick();
        drive(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
        n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL mid_err_set: got %b expected 1", err); end
        n_checks++; if (gnt_o !== 2'b01) begin n_errors++; $display("FAIL mid_rr_reset: got %b expected 01", gnt_o); end
        tick();
        drive(1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        n_checks++; if (rvalid_o !== 2'b01) begin n_errors++; $display("FAIL mid_rsp: got %b expected 01", rvalid_o); end
        tick();
    endtask

    initial begin
        rst_n = 1'b0; req = '0; sgnt = 1'b0; srvalid = 1'b0; srdata = '0;
        addr = '0; we = '0; be = '0; wdata = '0;
        m_lock = 0; m_lock_id = 0; m_rr = 0; m_err = 1'b0;
        test_reset();
        test_arbitration();
        test_wait_lock();
        test_fifo_full();
        test_push_pop();
        test_random();
        test_err();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/obi_interconnect_master_arb.md
Name: obi_interconnect_master_arb

Overview:
Per-slave OBI arbiter. It shares one slave port between MASTERS requesters and sits after the per-master slave-select decode in the system bus.
- Selects one requesting master per cycle, by round-robin or fixed priority.
- Muxes the selected master's address-phase signals onto the slave port.
- Holds the selection stable until the slave grants.
- Records the granted master ID in an in-order FIFO so each slave response returns to the correct master.

Parameters:
MASTERS, 2, number of requesting masters (>=2)
OUTSTANDING, 2, max accepted-but-unanswered transactions (ID FIFO depth, >=1)
MASTER_BITS, $clog2(MASTERS), width of a master index

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset, sampled on rising clk_i
master_req_i  in  MASTERS  per-master request, already qualified by slave select
master_addr_i  in  32 x MASTERS  per-master address
master_we_i  in  MASTERS  per-master write enable
master_be_i  in  4 x MASTERS  per-master byte enables
master_wdata_i  in  32 x MASTERS  per-master write data
master_gnt_o  out  MASTERS  per-master grant (at most one bit high)
master_rvalid_o  out  MASTERS  per-master response valid (at most one bit high)
master_rdata_o  out  32  slave_rdata_i broadcast to all masters
slave_req_o  out  1  request to slave
slave_addr_o  out  32  muxed address
slave_we_o  out  1  muxed write enable
slave_be_o  out  4  muxed byte enables
slave_wdata_o  out  32  muxed write data
slave_gnt_i  in  1  slave grant
slave_rvalid_i  in  1  slave response valid
slave_rdata_i  in  32  slave read data
err_o  out  1  sticky: rvalid received with no outstanding ID

Behaviour:
- Reset is synchronous, active-low.
  - State on reset: FIFO empty, rr_ptr=0, lock cleared, err_o=0.
  - While rst_ni=0, these outputs are forced to 0: slave_req_o, master_gnt_o, master_rvalid_o.
- Address-phase FSM has two states.
  - IDLE: sel = winner among master_req_i.
    - With round-robin: search from rr_ptr upward, wrapping modulo MASTERS.
    - slave_req_o = |master_req_i & !fifo_full.
    - If slave_req_o=1 and slave_gnt_i=0: latch sel into lock_id and go to WAIT.
  - WAIT: sel = lock_id, with no re-arbitration. slave_req_o = 1, held regardless of fifo_full because the push slot is already reserved.
    - On slave_gnt_i=1: go to IDLE.
    - If master_req_i[lock_id] drops, that is an OBI protocol violation by the master. The arbiter holds the request anyway (no special handling).
- slave_addr_o/we/be/wdata = master inputs indexed by sel, combinational. When slave_req_o=0 they are don't-care; drive them from sel.
- master_gnt_o[sel] = slave_req_o & slave_gnt_i, combinational (0-cycle grant path).
- On handshake (slave_req_o & slave_gnt_i):
  - Push sel into the ID FIFO.
  - With round-robin: rr_ptr <= (sel+1) mod MASTERS.
- Full/WAIT interaction:
  - fifo_full counts a WAIT reservation: the count includes the pending WAIT entry, so a push on grant can never overflow.
  - Full blocks new IDLE requests even when a pop occurs in the same cycle (no full-bypass).
- Response path:
  - slave_rvalid_i with FIFO non-empty: pop head; master_rvalid_o[head]=1 in the same cycle; master_rdata_o = slave_rdata_i.
  - Simultaneous push and pop: both take effect and the count is unchanged.
  - A response may arrive in the cycle after its grant at earliest. A same-cycle grant+rvalid pops the older entry.
  - slave_rvalid_i with FIFO empty: response dropped, no master_rvalid_o, err_o set to 1. err_o clears only on reset.
- FIFO pointers wrap modulo OUTSTANDING. The count register is wide enough to hold OUTSTANDING.
- Reset mid-transaction discards all outstanding IDs. Later stray rvalids set err_o.

Optional Feature:
- Macro: OBI_ARB_ROUND_ROBIN_EN.
- Defined: round-robin as above, with rr_ptr register and update.
- Undefined: fixed priority, lowest index wins. No rr_ptr register exists. The WAIT lock and the FIFO behave identically.

Test Plan:
- Masters 0 and 1 request continuously, slave_gnt_i=1, rvalid one cycle after each grant. Round-robin: grants alternate 0,1,0,1. Fixed: master 0 granted every cycle and master 1 starved.
- Master 1 requests alone with slave_gnt_i=0 for 3 cycles; master 0 requests from cycle 1. Master 1 stays selected and slave_addr_o stays at master 1's address until the grant in cycle 3; master 0 is granted next.
- OUTSTANDING=2, three back-to-back grants attempted with no rvalid. Third request blocked (slave_req_o=0) until the first rvalid. Responses return to masters in grant order.
- Grant to master 1 and rvalid for an earlier master 0 transaction in the same cycle. master_rvalid_o=2'b01 and FIFO count is unchanged.
- slave_rvalid_i pulsed with FIFO empty. No master_rvalid_o; err_o=1 and remains 1 until rst_ni=0.
- Reset asserted with 2 IDs outstanding. After reset: FIFO empty, rr_ptr=0, err_o=0, no master_rvalid_o. A subsequent rvalid sets err_o.
